// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage 16-bit pipeline.
// Merges hazard, branch, cache-miss and halt requests into per-stage write
// enables, flush/bubble controls and a PC redirect. The controls are
// combinational from state and inputs. The state, the pending redirect
// target, the drain counter and the saturating stall/flush counters are
// registered.
module pipeline_stall_ctrl #(
    parameter int PC_W      = 16,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             imem_miss,
    input  logic             dmem_miss,
    input  logic             halt_id,
    output logic             pc_we,
    output logic             redir_valid,
    output logic [PC_W-1:0]  redir_pc,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_REDIR_PEND = 2'd1,
        S_DRAIN      = 2'd2,
        S_HALTED     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [PC_W-1:0]  r_redir_pc;
    logic [DW-1:0]    r_drain_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic             w_capture;
    logic             w_drain_load;
    logic             w_drain_dec;

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Next state and Mealy controls; everything is held at 0 while reset is asserted.
    always_comb begin
        w_next_state = r_state;
        pc_we        = 1'b0;
        redir_valid  = 1'b0;
        redir_pc     = branch_target;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_we      = 1'b0;
        halted       = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_capture    = 1'b0;
        w_drain_load = 1'b0;
        w_drain_dec  = 1'b0;
        if (!rst_n) begin
            redir_pc = '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (dmem_miss) begin
                        // The whole pipe freezes; ID re-presents its request next cycle.
                        w_stall_inc = 1'b1;
                    end else if (hazard_stall) begin
                        id_ex_bubble = 1'b1;
                        pipe_we      = 1'b1;
                        w_stall_inc  = 1'b1;
                    end else if (halt_id) begin
                        if_id_flush  = 1'b1;
                        pipe_we      = 1'b1;
                        w_drain_load = 1'b1;
                        w_next_state = S_DRAIN;
                    end else if (branch_taken && !imem_miss) begin
                        pc_we       = 1'b1;
                        redir_valid = 1'b1;
                        if_id_we    = 1'b1;
                        if_id_flush = 1'b1;
                        pipe_we     = 1'b1;
                        w_flush_inc = 1'b1;
                    end else if (branch_taken) begin
                        // Fetch is stuck; hold the target until the I-cache answers.
                        if_id_flush  = 1'b1;
                        pipe_we      = 1'b1;
                        w_flush_inc  = 1'b1;
                        w_stall_inc  = 1'b1;
                        w_capture    = 1'b1;
                        w_next_state = S_REDIR_PEND;
                    end else if (imem_miss) begin
                        if_id_flush = 1'b1;
                        pipe_we     = 1'b1;
                        w_stall_inc = 1'b1;
                    end else begin
                        pc_we    = 1'b1;
                        if_id_we = 1'b1;
                        pipe_we  = 1'b1;
                    end
                end
                S_REDIR_PEND: begin
                    redir_valid = 1'b1;
                    redir_pc    = r_redir_pc;
                    if_id_flush = 1'b1;
                    pipe_we     = !dmem_miss;
                    if (imem_miss || dmem_miss) begin
                        w_stall_inc = 1'b1;
                    end else begin
                        pc_we        = 1'b1;
                        w_next_state = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if_id_flush = 1'b1;
                    pipe_we     = !dmem_miss;
                    if (!dmem_miss) begin
                        w_drain_dec = 1'b1;
                        if (r_drain_cnt <= DW'(1)) w_next_state = S_HALTED;
                    end
                end
                S_HALTED: begin
                    halted = 1'b1;
                end
                default: w_next_state = S_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_next_state;
    end

    // Pending redirect target and drain countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redir_pc  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_capture)         r_redir_pc  <= branch_target;
            if (w_drain_load)      r_drain_cnt <= DW'(DRAIN_CYC);
            else if (w_drain_dec)  r_drain_cnt <= r_drain_cnt - DW'(1);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the stall and flush requests of the 5-stage 16-bit pipeline and turns them into per-stage controls: PC write, IF/ID write and flush, ID/EX bubble, and freezing of the later pipeline registers.
- Inputs are `hazard_stall` (load-to-use or flag-before-branch), the branch resolution from ID, the I-cache and D-cache miss signals, and HLT decode.
- Holds a branch redirect that arrives during an I-cache miss until the miss clears.
- Drains the pipeline on HLT and keeps saturating stall and flush counters.

Parameters:
- PC_W, 16, width of PC and branch target.
- CNT_W, 16, width of the performance counters.
- DRAIN_CYC, 3, cycles from HLT leaving ID until it retires from WB.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- hazard_stall  input  1  stall request from hazard detection
- branch_taken  input  1  branch in ID resolved taken this cycle
- branch_target  input  PC_W  target for branch_taken
- imem_miss  input  1  I-cache not ready; fetched word invalid
- dmem_miss  input  1  D-cache not ready; MEM stage must hold
- halt_id  input  1  HLT opcode in ID (valid, not squashed)
- pc_we  output  1  PC register write enable
- redir_valid  output  1  PC mux selects redir_pc
- redir_pc  output  PC_W  redirect address
- if_id_we  output  1  IF/ID write enable
- if_id_flush  output  1  load NOP into IF/ID
- id_ex_bubble  output  1  load NOP into ID/EX
- pipe_we  output  1  enable for ID/EX, EX/MEM, MEM/WB
- halted  output  1  sticky halt indication
- stall_cnt  output  CNT_W  cycles with pc_we=0 in RUN/REDIR_PEND
- flush_cnt  output  CNT_W  cycles with if_id_flush=1 caused by branch

Behaviour:
Outputs and FSM:
- Control outputs are combinational (Mealy) from state and inputs.
- State, redirect register and counters are registered.
- States: RUN, REDIR_PEND, DRAIN, HALTED.
- Reset (async, rst_n=0), applied immediately:
  - state=RUN, counters=0, halted=0, redirect register=0.
  - All enables 0, flush, bubble and redir_valid 0.

RUN, priority per cycle (highest first):
1. dmem_miss=1:
   - pc_we=0, if_id_we=0, pipe_we=0, flush=0, bubble=0.
   - branch_taken, halt_id and hazard_stall are ignored; ID is frozen, so they re-present next cycle.
   - stall_cnt +1.
2. hazard_stall=1:
   - pc_we=0, if_id_we=0, id_ex_bubble=1, pipe_we=1.
   - branch_taken ignored, because a stalled branch re-resolves.
   - stall_cnt +1.
3. halt_id=1:
   - pc_we=0, if_id_flush=1, pipe_we=1.
   - Go to DRAIN with drain counter = DRAIN_CYC.
   - A simultaneous branch_taken is a decoder error and is ignored.
4. branch_taken=1 and imem_miss=0:
   - pc_we=1, redir_valid=1, redir_pc=branch_target (pass-through).
   - if_id_we=1, if_id_flush=1, pipe_we=1.
   - flush_cnt +1.
5. branch_taken=1 and imem_miss=1:
   - Capture branch_target; pc_we=0, if_id_flush=1, pipe_we=1.
   - flush_cnt +1, stall_cnt +1.
   - Go to REDIR_PEND.
6. imem_miss=1 only:
   - pc_we=0, if_id_flush=1, pipe_we=1.
   - stall_cnt +1.
7. Otherwise: pc_we=1, if_id_we=1, pipe_we=1, rest 0.

REDIR_PEND:
- redir_valid=1, redir_pc=captured target.
- if_id_flush=1; ID holds a NOP.
- pipe_we=!dmem_miss.
- While imem_miss=1 or dmem_miss=1: pc_we=0, stall_cnt +1.
- On the first cycle both are 0: pc_we=1, then go to RUN.
- The captured target is not overwritten. branch_taken and hazard_stall cannot assert here because ID holds a NOP; they are ignored.

DRAIN:
- pc_we=0, if_id_flush=1, pipe_we=!dmem_miss.
- The drain counter decrements only when dmem_miss=0.
- At 0, go to HALTED.

HALTED:
- halted=1, all enables 0, flush/bubble 0, counters frozen.
- Leaves HALTED only on reset.

Counters:
- Saturate at all-ones.
- Never wrap.

Test Plan:
1. RUN, hazard_stall=1 for 1 cycle:
   - That cycle: pc_we=0, if_id_we=0, id_ex_bubble=1, pipe_we=1.
   - stall_cnt 0->1; next cycle all enables 1.
2. branch_taken=1, branch_target=0x0040, no misses:
   - Same cycle: redir_valid=1, redir_pc=0x0040, pc_we=1, if_id_flush=1.
   - flush_cnt=1, state stays RUN.
3. branch_taken=1, target=0x0120, with imem_miss=1 for 3 cycles:
   - Enter REDIR_PEND; redir_pc holds 0x0120 while branch_target changes to 0xFFFF.
   - pc_we=0 for 3 cycles, stall_cnt=3.
   - Cycle 4: pc_we=1, redir_valid=1, then RUN.
4. dmem_miss=1 together with hazard_stall=1 and branch_taken=1:
   - All enables 0, bubble 0, redir_valid 0, stall_cnt +1, flush_cnt unchanged.
5. halt_id=1 with one dmem_miss cycle inside the drain:
   - DRAIN lasts 4 cycles with pc_we=0, then halted=1.
   - halted stays 1 for 10+ cycles while inputs toggle.
6. Drive imem_miss for 65540 cycles:
   - stall_cnt stops at 0xFFFF.
   - Reset in REDIR_PEND: redir_valid=0, counters=0, state RUN immediately without waiting for clk.
